// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache between fetch and memory controller.
// Define ICACHE_STATS_EN to add hit_cnt/miss_cnt statistics outputs.
module icache #(
   parameter int IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        flush,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic        mc_req,
   output logic [31:0] mc_addr,
   input  logic        mc_valid,
   input  logic [31:0] mc_instr
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {
      IDLE,
      MISS,
      DRAIN
   } state_t;

   state_t state, state_nx;

   logic [DEPTH-1:0] vld;
   logic [TAG_W-1:0] tag_a  [DEPTH];
   logic [31:0]      data_a [DEPTH];
   logic [31:0]      addr_q;

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0] rd_tag, wr_tag;
   logic             lookup, hit;
   logic             fill, respond;

   assign rd_idx  = if_addr[IDX_W+1:2];
   assign rd_tag  = if_addr[31:IDX_W+2];
   assign wr_idx  = addr_q[IDX_W+1:2];
   assign wr_tag  = addr_q[31:IDX_W+2];
   assign lookup  = (state == IDLE) && if_req && !flush;
   assign hit     = vld[rd_idx] && (tag_a[rd_idx] == rd_tag);
   assign mc_addr = addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else if (rdy) begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (lookup && !hit) state_nx = MISS;
         MISS: begin
            if (mc_valid)   state_nx = IDLE;
            else if (flush) state_nx = DRAIN;
         end
         DRAIN: if (mc_valid) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request drops in the completion cycle so the controller never re-arms.
   always_comb begin
      mc_req  = 1'b0;
      fill    = 1'b0;
      respond = 1'b0;
      unique case (state)
         IDLE: ;
         MISS: begin
            mc_req  = !mc_valid;
            fill    = mc_valid;
            respond = mc_valid && !flush;
         end
         DRAIN: begin
            mc_req = !mc_valid;
            fill   = mc_valid;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld      <= '0;
         addr_q   <= '0;
         if_valid <= 1'b0;
         if_instr <= '0;
      end else if (rdy) begin
         if_valid <= 1'b0;
         if (lookup) begin
            addr_q <= if_addr;
            if (hit) begin
               if_valid <= 1'b1;
               if_instr <= data_a[rd_idx];
            end
         end
         if (fill) vld[wr_idx] <= 1'b1;
         if (respond) begin
            if_valid <= 1'b1;
            if_instr <= mc_instr;
         end
      end
   end

   // Tag/data storage needs no reset; the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (rdy && fill) begin
         tag_a[wr_idx]  <= wr_tag;
         data_a[wr_idx] <= mc_instr;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (rdy && lookup) begin
         if (hit) hit_cnt  <= hit_cnt + 32'd1;
         else     miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected words queued on request, popped on if_valid.
// Controller responses are driven by hand so flush/reset timing is exact.
module tb_icache;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        if_req;
   logic [31:0] if_addr;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        mc_req;
   logic [31:0] mc_addr;
   logic        mc_valid;
   logic [31:0] mc_instr;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int          n_tests;
   int          n_fail;
   logic [31:0] sb[$];
   logic [31:0] sb_exp;

   icache #(.IDX_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .flush    (flush),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .mc_req   (mc_req),
      .mc_addr  (mc_addr),
      .mc_valid (mc_valid),
      .mc_instr (mc_instr)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && if_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", {31'd0, if_valid}, 32'd0);
         end else begin
            sb_exp = sb.pop_front();
            check("sb_instr", if_instr, sb_exp);
         end
      end
   end

   task automatic do_fetch(input logic [31:0] a, input bit exp_hit,
                           input logic [31:0] d, input int lat);
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = a;
      sb.push_back(d);
      @(negedge clk);
      if (exp_hit) begin
         check("hit_valid", {31'd0, if_valid}, 32'd1);
         check("hit_mcreq", {31'd0, mc_req}, 32'd0);
         if_req = 1'b0;
      end else begin
         check("miss_valid", {31'd0, if_valid}, 32'd0);
         for (int i = 0; i < lat; i++) begin
            check("miss_mcreq", {31'd0, mc_req}, 32'd1);
            check("miss_mcaddr", mc_addr, a);
            @(negedge clk);
         end
         mc_valid = 1'b1;
         mc_instr = d;
         #1;
         check("mcreq_drop", {31'd0, mc_req}, 32'd0);
         @(negedge clk);
         mc_valid = 1'b0;
         check("fill_valid", {31'd0, if_valid}, 32'd1);
         if_req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=%0t exp=finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b0;
      rdy      = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      flush    = 1'b0;
      mc_valid = 1'b0;
      mc_instr = '0;

      @(negedge clk);
      check("rst_valid", {31'd0, if_valid}, 32'd0);
      check("rst_instr", if_instr, 32'd0);
      check("rst_mcaddr", mc_addr, 32'd0);
      check("rst_mcreq", {31'd0, mc_req}, 32'd0);
      rst = 1'b1;

      // cold miss, hit, conflict replacement
      do_fetch(32'h0000_1000, 1'b0, 32'h0000_0013, 6);
      do_fetch(32'h0000_1000, 1'b1, 32'h0000_0013, 0);
      do_fetch(32'h0000_1100, 1'b0, 32'hAAAA_0001, 3);
`ifdef ICACHE_STATS_EN
      check("hit_cnt", hit_cnt, 32'd1);
      check("miss_cnt", miss_cnt, 32'd2);
`endif
      do_fetch(32'h0000_1100, 1'b1, 32'hAAAA_0001, 0);
      do_fetch(32'h0000_1000, 1'b0, 32'h0000_0013, 2);

      // flush two cycles into a miss -> drain without response
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_2000;
      @(negedge clk);
      check("drn_mcreq0", {31'd0, mc_req}, 32'd1);
      @(negedge clk);
      if_req = 1'b0;
      flush  = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("drn_mcreq1", {31'd0, mc_req}, 32'd1);
      check("drn_mcaddr", mc_addr, 32'h0000_2000);
      repeat (2) @(negedge clk);
      mc_valid = 1'b1;
      mc_instr = 32'h2222_2222;
      #1;
      check("drn_mcreq_drop", {31'd0, mc_req}, 32'd0);
      @(negedge clk);
      mc_valid = 1'b0;
      check("drn_novalid", {31'd0, if_valid}, 32'd0);
      do_fetch(32'h0000_2000, 1'b1, 32'h2222_2222, 0);

      // flush coinciding with mc_valid fills silently
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_3004;
      @(negedge clk);
      check("fm_mcreq", {31'd0, mc_req}, 32'd1);
      if_req   = 1'b0;
      flush    = 1'b1;
      mc_valid = 1'b1;
      mc_instr = 32'h3333_3333;
      @(negedge clk);
      flush    = 1'b0;
      mc_valid = 1'b0;
      check("fm_novalid", {31'd0, if_valid}, 32'd0);
      do_fetch(32'h0000_3004, 1'b1, 32'h3333_3333, 0);

      // flush in IDLE suppresses a same-cycle hit
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_3004;
      flush   = 1'b1;
      @(negedge clk);
      check("fi_novalid", {31'd0, if_valid}, 32'd0);
      check("fi_mcreq", {31'd0, mc_req}, 32'd0);
      if_req = 1'b0;
      flush  = 1'b0;

      // rdy low freezes a miss in progress
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_4008;
      @(negedge clk);
      check("rdy_mcreq0", {31'd0, mc_req}, 32'd1);
      rdy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rdy_mcreq", {31'd0, mc_req}, 32'd1);
         check("rdy_mcaddr", mc_addr, 32'h0000_4008);
         check("rdy_novalid", {31'd0, if_valid}, 32'd0);
      end
      rdy      = 1'b1;
      mc_valid = 1'b1;
      mc_instr = 32'h4444_0008;
      sb.push_back(32'h4444_0008);
      @(negedge clk);
      mc_valid = 1'b0;
      check("rdy_fill_valid", {31'd0, if_valid}, 32'd1);
      if_req = 1'b0;

      // reset in the middle of a miss
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 32'h0000_5000;
      @(negedge clk);
      check("rm_mcreq", {31'd0, mc_req}, 32'd1);
      if_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rm_valid", {31'd0, if_valid}, 32'd0);
      check("rm_mcreq_off", {31'd0, mc_req}, 32'd0);
      check("rm_mcaddr", mc_addr, 32'd0);
`ifdef ICACHE_STATS_EN
      check("rm_hit_cnt", hit_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      do_fetch(32'h0000_3004, 1'b0, 32'h3333_3333, 2);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
